// File: rtl/readout_sequencer_if.sv
// Handshake and bus bundle between the readout sequencer, the pixel array and the
// downstream byte consumer.
interface readout_sequencer_if #(
    parameter int horizontal_pixels = 2,
    parameter int vertical_pixels   = 2
);
    logic                           start;
    logic [8*horizontal_pixels-1:0] col_data;
    logic [vertical_pixels-1:0]     read;
    logic [7:0]                     out_data;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_first;
    logic                           out_last;
    logic                           busy;
    logic                           frame_done;
    logic                           err_overrun;

    modport master (
        input  start, col_data, out_ready,
        output read, out_data, out_valid, out_first, out_last, busy, frame_done, err_overrun
    );

    modport slave (
        output start, col_data, out_ready,
        input  read, out_data, out_valid, out_first, out_last, busy, frame_done, err_overrun
    );
endinterface

// File: rtl/readout_sequencer.sv
// Row-by-row pixel array readout: select a row, let it settle, capture the column
// bus, then stream the captured bytes out over a valid/ready handshake.
module readout_sequencer #(
    parameter int horizontal_pixels = 2,
    parameter int vertical_pixels   = 2,
    parameter int settle_cycles     = 2
) (
    input  logic                clk,
    input  logic                reset,
    readout_sequencer_if.master bus
);
    localparam int CW = (horizontal_pixels > 1) ? $clog2(horizontal_pixels) : 1;
    localparam int RW = (vertical_pixels > 1) ? $clog2(vertical_pixels) : 1;
    localparam logic [CW-1:0] COL_LAST    = CW'(horizontal_pixels - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(vertical_pixels - 1);
    localparam logic [7:0]    SETTLE_LAST = 8'(settle_cycles - 1);

    typedef enum logic [1:0] {IDLE, SELECT, CAPTURE, STREAM} state_t;

    // With no settle time a row goes straight from selection to capture.
    localparam state_t ROW_ENTRY = (settle_cycles == 0) ? CAPTURE : SELECT;

    state_t                         state_q, state_d;
    logic [RW-1:0]                  row_idx_q, row_idx_d;
    logic [CW-1:0]                  col_idx_q, col_idx_d;
    logic [7:0]                     settle_q, settle_d;
    logic [8*horizontal_pixels-1:0] row_buf_q, row_buf_d;
    logic                           frame_done_q, frame_done_d;
    logic                           err_q, err_d;
    logic                           hs;

    assign hs = (state_q == STREAM) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            row_idx_q    <= '0;
            col_idx_q    <= '0;
            settle_q     <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_idx_q    <= row_idx_d;
            col_idx_q    <= col_idx_d;
            settle_q     <= settle_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    // Row buffer content is don't-care after reset; it is always refilled before use.
    always_ff @(posedge clk) begin
        row_buf_q <= row_buf_d;
    end

    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        col_idx_d    = col_idx_q;
        settle_d     = settle_q;
        row_buf_d    = row_buf_q;
        frame_done_d = 1'b0;
        err_d        = err_q | (bus.start & (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    row_idx_d = '0;
                    col_idx_d = '0;
                    settle_d  = '0;
                    state_d   = ROW_ENTRY;
                end
            end
            SELECT: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = CAPTURE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            CAPTURE: begin
                row_buf_d = bus.col_data;
                state_d   = STREAM;
            end
            STREAM: begin
                if (hs) begin
                    if (col_idx_q == COL_LAST) begin
                        col_idx_d = '0;
                        if (row_idx_q == ROW_LAST) begin
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            row_idx_d = row_idx_q + 1'b1;
                            state_d   = ROW_ENTRY;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so they hold steady under backpressure.
    always_comb begin
        bus.read        = '0;
        bus.out_data    = '0;
        bus.out_valid   = 1'b0;
        bus.out_first   = 1'b0;
        bus.out_last    = 1'b0;
        bus.busy        = (state_q != IDLE);
        bus.frame_done  = frame_done_q;
        bus.err_overrun = err_q;
        if (state_q == SELECT || state_q == CAPTURE) begin
            for (int r = 0; r < vertical_pixels; r++) begin
                bus.read[r] = (row_idx_q == RW'(r));
            end
        end
        if (state_q == STREAM) begin
            bus.out_valid = 1'b1;
            for (int c = 0; c < horizontal_pixels; c++) begin
                if (col_idx_q == CW'(c)) begin
                    bus.out_data = row_buf_q[8*c +: 8];
                end
            end
            bus.out_first = (row_idx_q == '0) && (col_idx_q == '0);
            bus.out_last  = (row_idx_q == ROW_LAST) && (col_idx_q == COL_LAST);
        end
    end
endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: two instances (H2/V2/S2 and H3/V1/S0), each
// with a byte scoreboard drained by its own monitor.
module tb_readout_sequencer;
    logic clk;
    logic reset;
    logic start_a, start_b;
    logic ready;
    logic mon_en;
    int   n_tests;
    int   n_fail;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];
    logic [9:0] e_a, e_b;

    readout_sequencer_if #(.horizontal_pixels(2), .vertical_pixels(2)) bus_a();
    readout_sequencer_if #(.horizontal_pixels(3), .vertical_pixels(1)) bus_b();

    readout_sequencer #(.horizontal_pixels(2), .vertical_pixels(2), .settle_cycles(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    readout_sequencer #(.horizontal_pixels(3), .vertical_pixels(1), .settle_cycles(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    // Pixel array model: selected row drives the column bus, otherwise junk.
    assign bus_a.col_data  = (bus_a.read == 2'b01) ? 16'hB2A1 :
                             (bus_a.read == 2'b10) ? 16'hD4C3 : 16'hEEEE;
    assign bus_b.col_data  = (bus_b.read == 1'b1) ? 24'h332211 : 24'hEEEEEE;
    assign bus_a.start     = start_a;
    assign bus_b.start     = start_b;
    assign bus_a.out_ready = ready;
    assign bus_b.out_ready = ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en && bus_a.out_valid === 1'b1 && ready) begin
            if (q_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_unexpected_byte: got %0h expected none", bus_a.out_data);
            end else begin
                e_a = q_a.pop_front();
                chk("a_byte", {bus_a.out_data, bus_a.out_first, bus_a.out_last}, e_a);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && bus_b.out_valid === 1'b1 && ready) begin
            if (q_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL b_unexpected_byte: got %0h expected none", bus_b.out_data);
            end else begin
                e_b = q_b.pop_front();
                chk("b_byte", {bus_b.out_data, bus_b.out_first, bus_b.out_last}, e_b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame_a();
        q_a.push_back({8'hA1, 1'b1, 1'b0});
        q_a.push_back({8'hB2, 1'b0, 1'b0});
        q_a.push_back({8'hC3, 1'b0, 1'b0});
        q_a.push_back({8'hD4, 1'b0, 1'b1});
    endtask

    task automatic do_reset();
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b1;
        step(); step();
        chk("rst_read",  bus_a.read, 0);
        chk("rst_valid", bus_a.out_valid, 0);
        chk("rst_data",  bus_a.out_data, 0);
        chk("rst_fl",    {bus_a.out_first, bus_a.out_last}, 0);
        chk("rst_busy",  bus_a.busy, 0);
        chk("rst_done",  bus_a.frame_done, 0);
        chk("rst_err",   bus_a.err_overrun, 0);
        chk("rst_b",     {bus_b.busy, bus_b.read, bus_b.out_valid}, 0);
        reset = 1'b0;
    endtask

    function automatic logic [1:0] exp_read_a(int m);
        if (m >= 1 && m <= 3) return 2'b01;
        if (m >= 6 && m <= 8) return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        n_tests = 0; n_fail = 0; mon_en = 1'b0;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b1;
        do_reset();
        mon_en = 1'b1;

        // Two back-to-back frames; the second start coincides with frame_done.
        push_frame_a(); push_frame_a();
        start_a = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            int m;
            step();
            start_a = 1'b0;
            m = (k - 1) % 11 + 1;
            chk("t1_read",  bus_a.read, exp_read_a(m));
            chk("t1_valid", bus_a.out_valid, (m == 4 || m == 5 || m == 9 || m == 10) ? 1 : 0);
            chk("t1_done",  bus_a.frame_done, (m == 11) ? 1 : 0);
            if (k == 11) start_a = 1'b1;
        end
        chk("t1_err", bus_a.err_overrun, 0);
        chk("t1_q_empty", q_a.size(), 0);

        // Backpressure on the first byte for three cycles.
        do_reset();
        push_frame_a();
        start_a = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            start_a = 1'b0;
            ready = !(k >= 4 && k <= 6);
            chk("t2_read", bus_a.read, (k <= 3) ? 1 : (k >= 9 && k <= 11) ? 2 : 0);
            chk("t2_valid", bus_a.out_valid,
                ((k >= 4 && k <= 8) || k == 12 || k == 13) ? 1 : 0);
            if (k >= 4 && k <= 7)
                chk("t2_stall_hold", {bus_a.out_data, bus_a.out_first, bus_a.out_last, bus_a.busy},
                    {8'hA1, 1'b1, 1'b0, 1'b1});
            chk("t2_done", bus_a.frame_done, (k == 14) ? 1 : 0);
        end
        chk("t2_q_empty", q_a.size(), 0);

        // Start while busy sets the sticky overrun flag without disturbing the frame.
        do_reset();
        push_frame_a();
        start_a = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            start_a = (k == 5);
            chk("t3_err", bus_a.err_overrun, (k >= 6) ? 1 : 0);
            if (k <= 11) chk("t3_read", bus_a.read, exp_read_a(k));
            chk("t3_done", bus_a.frame_done, (k == 11) ? 1 : 0);
        end
        chk("t3_busy_after", bus_a.busy, 0);
        chk("t3_q_empty", q_a.size(), 0);

        // Reset during row 1 SELECT aborts the frame.
        do_reset();
        q_a.push_back({8'hA1, 1'b1, 1'b0});
        q_a.push_back({8'hB2, 1'b0, 1'b0});
        start_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            start_a = (k == 2);
            reset = (k == 7);
            if (k == 7) chk("t4_pre_state", {bus_a.read, bus_a.err_overrun, bus_a.busy}, 4'b1011);
            if (k == 8) chk("t4_abort", {bus_a.read, bus_a.busy, bus_a.out_valid, bus_a.err_overrun}, 0);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t4_quiet", {bus_a.frame_done, bus_a.out_valid, bus_a.read, bus_a.busy}, 0);
        end
        chk("t4_q_empty", q_a.size(), 0);
        push_frame_a();
        start_a = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            start_a = 1'b0;
            chk("t4_read", bus_a.read, exp_read_a(k));
            chk("t4_done", bus_a.frame_done, (k == 11) ? 1 : 0);
        end
        chk("t4_q_empty2", q_a.size(), 0);

        // Zero settle, three columns, single row.
        do_reset();
        q_b.push_back({8'h11, 1'b1, 1'b0});
        q_b.push_back({8'h22, 1'b0, 1'b0});
        q_b.push_back({8'h33, 1'b0, 1'b1});
        start_b = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            start_b = 1'b0;
            chk("t5_read",  bus_b.read, (k == 1) ? 1 : 0);
            chk("t5_valid", bus_b.out_valid, (k >= 2 && k <= 4) ? 1 : 0);
            chk("t5_done",  bus_b.frame_done, (k == 5) ? 1 : 0);
        end
        chk("t5_q_empty", q_b.size(), 0);
        chk("t5_a_idle", bus_a.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/readout_sequencer.md
READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 Parameter horizontal_pixels, default 2, columns per row (bytes captured per row), SHALL be >=1.
REQ-002 Parameter vertical_pixels, default 2, rows per frame, SHALL be >=1.
REQ-003 Parameter settle_cycles, default 2, cycles a row select SHALL be held before capture, 0..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to read out one converted frame.
REQ-007 col_data  input  8*horizontal_pixels  column bus from pixel array; column c on bits [8c+7:8c].
REQ-008 read  output  vertical_pixels  one-hot row select to pixel array.
REQ-009 out_data  output  8  pixel byte stream.
REQ-010 out_valid  output  1  out_data holds a valid byte.
REQ-011 out_ready  input  1  downstream accepts byte when high with out_valid.
REQ-012 out_first  output  1  high with first byte of frame (row 0, column 0).
REQ-013 out_last  output  1  high with final byte of frame.
REQ-014 busy  output  1  high whenever not IDLE.
REQ-015 frame_done  output  1  one-cycle pulse after final byte handshake.
REQ-016 err_overrun  output  1  sticky flag: start seen while busy.

Function
REQ-017 FSM states SHALL be IDLE, SELECT, CAPTURE, STREAM; registers row_idx, col_idx, settle counter, row buffer (8*horizontal_pixels bits).
REQ-018 IDLE: start=1 SHALL clear row_idx, col_idx and go to SELECT (or CAPTURE if settle_cycles=0); start=0 stays IDLE.
REQ-019 SELECT SHALL last exactly settle_cycles cycles with read = one-hot(row_idx), then go to CAPTURE.
REQ-020 CAPTURE SHALL last one cycle with read = one-hot(row_idx) and SHALL register col_data into the row buffer at that cycle's closing edge, then go to STREAM.
REQ-021 read SHALL be all-zero in IDLE and STREAM; never more than one bit high.
REQ-022 STREAM: out_valid=1, out_data = row buffer byte col_idx; on out_valid&out_ready col_idx increments.
REQ-023 out_data, out_first, out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Handshake on column horizontal_pixels-1: col_idx clears; if row_idx < vertical_pixels-1 then row_idx increments and FSM enters SELECT (CAPTURE if settle_cycles=0); else FSM enters IDLE.
REQ-025 out_first SHALL be high only while STREAM with row_idx=0, col_idx=0; out_last only while row_idx=vertical_pixels-1, col_idx=horizontal_pixels-1.
REQ-026 frame_done SHALL pulse for one cycle, the cycle after the out_last handshake (FSM in IDLE).
REQ-027 start while busy=1 SHALL be ignored for sequencing and SHALL set err_overrun; err_overrun clears only on reset.
REQ-028 start in the same cycle as frame_done (FSM IDLE) SHALL be accepted normally.
REQ-029 Latency: start accepted at cycle 0 -> read high cycles 1..settle_cycles+1, first out_valid at cycle settle_cycles+2 (zero backpressure).
REQ-030 Row turnaround: cycles from last handshake of a row to next out_valid SHALL be settle_cycles+2.
REQ-031 Zero backpressure frame SHALL take vertical_pixels*(settle_cycles+1+horizontal_pixels) cycles from SELECT entry to IDLE.
REQ-032 col_data outside CAPTURE SHALL have no effect.

Reset
REQ-033 reset=1 at a rising edge SHALL force IDLE, clear row_idx, col_idx, settle counter, err_overrun; row buffer contents undefined.
REQ-034 Outputs after reset: read=0, out_valid=0, out_data=0, out_first=0, out_last=0, busy=0, frame_done=0.
REQ-035 reset mid-frame (any state) SHALL drop read and out_valid the next cycle, with no frame_done and no further bytes; reset has priority over start.

Verification (H=2, V=2, S=2 unless stated)
REQ-036 start pulse, out_ready=1, col_data row0=16'hB2A1, row1=16'hD4C3 -> read=01 cycles 1-3, bytes A1,B2 cycles 4-5, read=10 cycles 6-8, bytes C3,D4 cycles 9-10, out_first with A1, out_last with D4, frame_done cycle 11.
REQ-037 out_ready held 0 three cycles at first byte -> out_valid stays 1, out_data=A1 stable, out_first stable, no read asserted, sequence resumes unchanged.
REQ-038 start pulsed again at cycle 5 -> err_overrun=1 from cycle 6 until reset, frame output identical to REQ-036.
REQ-039 reset asserted in cycle 7 (row 1 SELECT) -> read=0, busy=0 from cycle 8, no frame_done, err_overrun=0; subsequent start produces complete frame.
REQ-040 settle_cycles=0, H=3, V=1, out_ready=1 -> read=1 only cycle 1, bytes cycles 2-4, out_first and out_last on correct bytes, frame_done cycle 5.
